// File: rtl/mipi_csi_rx_bridge.sv
// MIPI CSI-2 D-PHY receive bridge: 4-lane DDR capture, LP/HS detection,
// per-lane sync-byte alignment, long-packet header parse and 32-bit payload
// word output with frame/line sync flags.
module mipi_csi_rx_bridge #(
  parameter int         LANES     = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hB8,
  parameter int         WC_WIDTH  = 16
) (
  input  logic               clk_i,
  input  logic               reset_in,
  input  logic               mipi_clk_lpp_io,
  input  logic               mipi_clk_lpn_io,
  input  logic [LANES-1:0]   mipi_data_in,
  input  logic [LANES-1:0]   mipi_data_lpp_io,
  input  logic [LANES-1:0]   mipi_data_lpn_io,
  output logic               clk_out,
  output logic [8*LANES-1:0] data_out,
  output logic               fsyn_out,
  output logic               lsync_out,
  output logic [2:0]         debug_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HUNT    = 3'd1,
    HEADER  = 3'd2,
    PAYLOAD = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Payload words for a byte count, rounding a partial last word up.
  function automatic logic [WC_WIDTH-1:0] words_from_wc(input logic [WC_WIDTH-1:0] wc);
    logic [WC_WIDTH:0] sum;
    sum = {1'b0, wc} + (WC_WIDTH+1)'(3);
    return WC_WIDTH'(sum >> 2);
  endfunction

  // Byte of a 9-bit history window at the even (upper) or odd (lower) offset.
  function automatic logic [7:0] align_byte(input logic [8:0] win, input logic odd);
    return odd ? win[7:0] : win[8:1];
  endfunction

  state_t                 state_q, state_d;
  logic [LANES-1:0]       rise_p0, fall_p0;
  logic [8:0]             hist_p1 [LANES];
  logic [8*LANES-1:0]     word_p1;
  logic                   byte_vld_p1;
  logic [1:0]             phase_q, phase_d;
  logic [LANES-1:0]       off_q;
  logic [LANES-1:0]       lp01_seen_q;
  logic [WC_WIDTH-1:0]    words_q;
  logic [LANES-1:0]       match_even, match_odd;
  logic [LANES-1:0]       lane_stop, lane_lp00, lane_lp01;
  logic                   any_stop, all_stop, all_hs, sync_hit;
  logic [7:0]             hdr_id;
  logic [WC_WIDTH-1:0]    hdr_wc;
  logic                   hdr_short;

  assign lane_stop   = mipi_data_lpp_io & mipi_data_lpn_io;
  assign lane_lp00   = ~mipi_data_lpp_io & ~mipi_data_lpn_io;
  assign lane_lp01   = ~mipi_data_lpp_io & mipi_data_lpn_io;
  assign any_stop    = |lane_stop;
  assign all_stop    = &lane_stop;
  // A lane is in HS only after it has walked LP-01 -> LP-00.
  assign all_hs      = &(lane_lp00 & lp01_seen_q);
  assign sync_hit    = &(match_even | match_odd);
  assign byte_vld_p1 = (phase_q == 2'd3);
  assign hdr_id      = word_p1[7:0];
  assign hdr_wc      = word_p1[8 +: WC_WIDTH];
  assign hdr_short   = (hdr_id < 8'h10) || (hdr_wc == '0);
  assign debug_state = state_q;

  // Stage p0: rising-edge bit of each lane
  always_ff @(posedge clk_i or posedge reset_in) begin
    if (reset_in) rise_p0 <= '0;
    else          rise_p0 <= mipi_data_in;
  end

  // Stage p0: falling-edge bit of each lane
  always_ff @(negedge clk_i or posedge reset_in) begin
    if (reset_in) fall_p0 <= '0;
    else          fall_p0 <= mipi_data_in;
  end

  // Stage p1: per-lane history, LSB first, two bits per cycle; flushed in IDLE
  always_ff @(posedge clk_i or posedge reset_in) begin
    if (reset_in) begin
      for (int n = 0; n < LANES; n++) hist_p1[n] <= '0;
    end else begin
      for (int n = 0; n < LANES; n++) begin
        if (state_q == IDLE) hist_p1[n] <= '0;
        else                 hist_p1[n] <= {fall_p0[n], rise_p0[n], hist_p1[n][8:2]};
      end
    end
  end

  // Sync-byte matchers and lane-aligned word assembly from the history windows
  always_comb begin
    match_even = '0;
    match_odd  = '0;
    word_p1    = '0;
    for (int n = 0; n < LANES; n++) begin
      match_even[n]     = (hist_p1[n][8:1] == SYNC_BYTE);
      match_odd[n]      = (hist_p1[n][7:0] == SYNC_BYTE);
      word_p1[8*n +: 8] = align_byte(hist_p1[n], off_q[n]);
    end
  end

  // Next-state logic; a stop state on any lane aborts reception at once
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (all_hs) state_d = HUNT;
      HUNT: begin
        if (any_stop)      state_d = IDLE;
        else if (sync_hit) state_d = HEADER;
      end
      HEADER: begin
        if (any_stop)         state_d = IDLE;
        else if (byte_vld_p1) state_d = hdr_short ? DONE : PAYLOAD;
      end
      PAYLOAD: begin
        if (any_stop)                                    state_d = IDLE;
        else if (byte_vld_p1 && words_q == WC_WIDTH'(1)) state_d = DONE;
      end
      DONE:    if (all_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte phase free-runs and is re-zeroed on the sync cycle
  assign phase_d = (state_q == HUNT && state_d == HEADER) ? 2'd0 : phase_q + 2'd1;

  // FSM state register
  always_ff @(posedge clk_i or posedge reset_in) begin
    if (reset_in) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Control: byte phase, per-lane bit offset, LP-01 tracking, word counter
  always_ff @(posedge clk_i or posedge reset_in) begin
    if (reset_in) begin
      phase_q     <= '0;
      off_q       <= '0;
      lp01_seen_q <= '0;
      words_q     <= '0;
    end else begin
      phase_q     <= phase_d;
      lp01_seen_q <= (lp01_seen_q | lane_lp01) & ~lane_stop;
      if (state_q == HUNT && state_d == HEADER)
        off_q <= ~match_even;
      if (state_q == IDLE)
        words_q <= '0;
      else if (state_q == HEADER && byte_vld_p1)
        words_q <= words_from_wc(hdr_wc);
      else if (state_q == PAYLOAD && byte_vld_p1)
        words_q <= words_q - WC_WIDTH'(1);
    end
  end

  // Stage p2: word clock, payload word, line and frame sync
  always_ff @(posedge clk_i or posedge reset_in) begin
    if (reset_in) begin
      clk_out   <= 1'b0;
      data_out  <= '0;
      lsync_out <= 1'b0;
      fsyn_out  <= 1'b0;
    end else begin
      // Low for phases 0-1, high for 2-3, so words change on the falling edge.
      clk_out <= phase_d[1];
      if (!mipi_clk_lpp_io && !mipi_clk_lpn_io)    fsyn_out <= 1'b1;
      else if (mipi_clk_lpp_io && mipi_clk_lpn_io) fsyn_out <= 1'b0;
      if (state_q == PAYLOAD && !any_stop && byte_vld_p1) begin
        data_out  <= word_p1;
        lsync_out <= 1'b1;
      end else if (state_q == PAYLOAD && any_stop) begin
        lsync_out <= 1'b0;
      end else if (state_q == DONE && (byte_vld_p1 || all_stop)) begin
        lsync_out <= 1'b0;
      end else if (state_q != PAYLOAD && state_q != DONE) begin
        lsync_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mipi_csi_rx_bridge.sv
// Bench for mipi_csi_rx_bridge: drives DDR lane bit streams with LP
// sequencing, scoreboards payload words sampled on the word clock.
module tb_mipi_csi_rx_bridge;

  logic        clk_i = 1'b0;
  logic        clk_en = 1'b0;
  logic        reset_in;
  logic        mipi_clk_lpp_io, mipi_clk_lpn_io;
  logic [3:0]  mipi_data_in, mipi_data_lpp_io, mipi_data_lpn_io;
  logic        clk_out;
  logic [31:0] data_out;
  logic        fsyn_out, lsync_out;
  logic [2:0]  debug_state;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          words_rx = 0;
  int          pulses = 0;
  int          clk_rises = 0;
  int          lead [4];
  logic [7:0]  hdr_b [4];
  int          nw_drive = 0;

  // Clock held until the reset checks are done
  always #5 if (clk_en) clk_i = ~clk_i;

  mipi_csi_rx_bridge dut (
    .clk_i            (clk_i),
    .reset_in         (reset_in),
    .mipi_clk_lpp_io  (mipi_clk_lpp_io),
    .mipi_clk_lpn_io  (mipi_clk_lpn_io),
    .mipi_data_in     (mipi_data_in),
    .mipi_data_lpp_io (mipi_data_lpp_io),
    .mipi_data_lpn_io (mipi_data_lpn_io),
    .clk_out          (clk_out),
    .data_out         (data_out),
    .fsyn_out         (fsyn_out),
    .lsync_out        (lsync_out),
    .debug_state      (debug_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    case (i % 5)
      0:       return 32'h00FF55AA;
      1:       return 32'h0000FF55;
      2:       return 32'hAA0000FF;
      3:       return 32'h55AA0000;
      default: return 32'hFF55AA00;
    endcase
  endfunction

  // Bit on lane n at half-cycle slot: lead zeros, sync, header, payload, zeros.
  function automatic logic get_bit(input int n, input int slot);
    int s;
    int b;
    logic [7:0]  by;
    logic [31:0] w;
    s = slot - lead[n];
    if (s < 0) return 1'b0;
    b = s / 8;
    if (b == 0)                by = 8'hB8;
    else if (b == 1)           by = hdr_b[n];
    else if (b - 2 < nw_drive) begin w = pat(b - 2); by = w[8*n +: 8]; end
    else                       by = 8'h00;
    return by[s % 8];
  endfunction

  task automatic drive_cycle(input logic [3:0] r, input logic [3:0] f);
    @(negedge clk_i); #2 mipi_data_in = r;
    @(posedge clk_i); #2 mipi_data_in = f;
  endtask

  task automatic lp_cycles(input logic [3:0] lpp, input logic [3:0] lpn, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i); #2;
      mipi_data_lpp_io = lpp;
      mipi_data_lpn_io = lpn;
      mipi_data_in     = 4'h0;
    end
  endtask

  // mode 0: complete line, 1: LP-11 abort, 2: reset abort
  task automatic send_line(input logic [7:0] id, input logic [15:0] wc, input int nw_send,
                           input int mode, input logic [3:0] skew);
    int base_rx;
    int base_p;
    int ncyc;
    logic [3:0] r, f;
    hdr_b[0] = id;
    hdr_b[1] = wc[7:0];
    hdr_b[2] = wc[15:8];
    hdr_b[3] = 8'h00;
    for (int n = 0; n < 4; n++) lead[n] = skew[n] ? 5 : 6;
    nw_drive = nw_send;
    for (int i = 0; i < nw_send; i++) exp_q.push_back(pat(i));
    base_rx = words_rx;
    base_p  = pulses;
    lp_cycles(4'hF, 4'hF, 2);
    lp_cycles(4'h0, 4'hF, 2);
    lp_cycles(4'h0, 4'h0, 3);
    ncyc = (6 + 16 + 8 * nw_send) / 2 + 4;
    for (int c = 0; c < ncyc; c++) begin
      for (int n = 0; n < 4; n++) begin
        r[n] = get_bit(n, 2 * c);
        f[n] = get_bit(n, 2 * c + 1);
      end
      drive_cycle(r, f);
    end
    if (mode == 0) begin
      check_eq("state_done", {29'b0, debug_state}, 32'd4);
      lp_cycles(4'hF, 4'hF, 2);
      check_eq("state_idle_after_stop", {29'b0, debug_state}, 32'd0);
    end else if (mode == 1) begin
      lp_cycles(4'hF, 4'hF, 2);
      check_eq("state_idle_abort", {29'b0, debug_state}, 32'd0);
      check_eq("lsync_drop_abort", {31'b0, lsync_out}, 32'd0);
    end else begin
      reset_in = 1'b1;
      #1;
      check_eq("rst_mid_state", {29'b0, debug_state}, 32'd0);
      check_eq("rst_mid_lsync", {31'b0, lsync_out}, 32'd0);
      check_eq("rst_mid_data", data_out, 32'd0);
      check_eq("rst_mid_clkout", {31'b0, clk_out}, 32'd0);
      @(negedge clk_i);
      mipi_data_lpp_io = 4'hF;
      mipi_data_lpn_io = 4'hF;
      reset_in = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 check_eq("fsyn_after_reset", {31'b0, fsyn_out}, 32'd1);
    end
    check_eq("words_per_line", words_rx - base_rx, nw_send);
    check_eq("lsync_pulses", pulses - base_p, (nw_send > 0) ? 1 : 0);
    check_eq("queue_drained", exp_q.size(), 0);
  endtask

  // Scoreboard: pop one expected word per word-clock rise while lsync is high
  initial forever begin
    @(posedge clk_out);
    #1;
    if (lsync_out) begin
      if (exp_q.size() == 0) check_eq("extra_word", {31'b0, lsync_out}, 32'd0);
      else begin
        check_eq("payload_word", data_out, exp_q.pop_front());
        words_rx++;
      end
    end
  end

  // Line pulse and word-clock edge counters
  always @(posedge lsync_out) pulses++;
  always @(posedge clk_out) clk_rises++;

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached after %0d tests", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int p0;
    reset_in         = 1'b1;
    mipi_clk_lpp_io  = 1'b1;
    mipi_clk_lpn_io  = 1'b1;
    mipi_data_lpp_io = 4'hF;
    mipi_data_lpn_io = 4'hF;
    mipi_data_in     = 4'h0;
    #20;
    check_eq("rst_data", data_out, 32'd0);
    check_eq("rst_lsync", {31'b0, lsync_out}, 32'd0);
    check_eq("rst_fsyn", {31'b0, fsyn_out}, 32'd0);
    check_eq("rst_clkout", {31'b0, clk_out}, 32'd0);
    check_eq("rst_state", {29'b0, debug_state}, 32'd0);
    reset_in = 1'b0;
    #20;
    check_eq("state_after_release", {29'b0, debug_state}, 32'd0);
    clk_en = 1'b1;
    repeat (4) @(posedge clk_i);

    // Frame sync follows the clock lane
    #2 begin mipi_clk_lpp_io = 1'b0; mipi_clk_lpn_io = 1'b0; end
    repeat (2) @(posedge clk_i);
    #1 check_eq("fsyn_hs", {31'b0, fsyn_out}, 32'd1);
    mipi_clk_lpp_io = 1'b1; mipi_clk_lpn_io = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 check_eq("fsyn_stop", {31'b0, fsyn_out}, 32'd0);
    mipi_clk_lpp_io = 1'b0; mipi_clk_lpn_io = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 check_eq("fsyn_hs_again", {31'b0, fsyn_out}, 32'd1);

    // Word clock free-runs at clk_i/4
    base = clk_rises;
    repeat (40) @(posedge clk_i);
    #1 check_eq("clk_out_rate", clk_rises - base, 10);

    // RAW10 line, WC=2400
    send_line(8'h2B, 16'd2400, 600, 0, 4'b0000);

    // Ten back-to-back lines, one with lanes 1 and 3 a bit early
    p0 = pulses;
    for (int k = 0; k < 10; k++)
      send_line(8'h2B, 16'd2400, 600, 0, (k == 4) ? 4'b1010 : 4'b0000);
    check_eq("ten_line_pulses", pulses - p0, 10);
    check_eq("fsyn_held", {31'b0, fsyn_out}, 32'd1);

    // Short packet, zero word count, and a partial last word
    send_line(8'h00, 16'h0001, 0, 0, 4'b0000);
    send_line(8'h2B, 16'd0, 0, 0, 4'b0000);
    send_line(8'h2B, 16'd10, 3, 0, 4'b0000);

    // LP-11 abort mid-payload, then a clean line
    send_line(8'h2B, 16'd2400, 20, 1, 4'b0000);
    send_line(8'h2B, 16'd2400, 600, 0, 4'b0101);

    // Reset mid-payload, then a clean RAW12 line
    send_line(8'h2B, 16'd2400, 8, 2, 4'b0000);
    send_line(8'h2C, 16'd8, 2, 0, 4'b0000);

    check_eq("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mipi_csi_rx_bridge.md
Name: mipi_csi_rx_bridge

Overview:
Receives a 4-lane MIPI CSI-2 D-PHY stream, detects LP/HS transitions, and aligns each lane on the 0xB8 sync byte. It parses the long-packet header and emits the packet payload as 32-bit words with frame and line sync flags. It sits between the D-PHY pins (HS lanes plus LP comparator inputs) and the pixel-processing pipeline. Single clock domain: clk_i is the forwarded HS DDR bit clock.

Parameters:
LANES, 4, number of data lanes (fixed at 4 in this revision)
SYNC_BYTE, 8'hB8, HS leader sync pattern
WC_WIDTH, 16, packet word-count width

Ports:
clk_i  in  1  HS DDR bit clock; lanes sampled on both edges
reset_in  in  1  asynchronous active-high reset
mipi_clk_lpp_io  in  1  clock-lane LP positive
mipi_clk_lpn_io  in  1  clock-lane LP negative
mipi_data_in  in  4  HS lane bits; [n] = lane n
mipi_data_lpp_io  in  4  data-lane LP positive, per lane
mipi_data_lpn_io  in  4  data-lane LP negative, per lane
clk_out  out  1  word clock, clk_i/4, registered
data_out  out  32  payload word; [7:0]=lane0 byte (first byte) .. [31:24]=lane3 byte
fsyn_out  out  1  frame sync
lsync_out  out  1  line sync / payload valid
debug_state  out  3  current FSM state code

Behaviour:
- Reset: all outputs 0, FSM = IDLE, shift registers and counters cleared.
- Capture: per lane, bit on rising edge then bit on falling edge of clk_i, LSB first; gives 2 bits/lane/cycle and one byte/lane every 4 cycles.
- fsyn_out: registered, 1 while clock lane is LP-00 (HS active); 0 at LP-11 (stop).
- LP decode: lane LP-11 = stop; LP-01 then LP-00 = HS request. All 4 lanes must reach LP-00 before leaving IDLE.
- FSM states:
  - IDLE(0): wait for all data lanes LP-00 → HUNT.
  - HUNT(1): per lane, keep a 9-bit history window. Match SYNC_BYTE at even or odd bit offset. Sync = all 4 lanes match in the same cycle; latch bit offset and byte phase → HEADER.
  - HEADER(2): after 4 cycles, assemble header {lane3..lane0} = {ECC, WC_msb, WC_lsb, DataID}.
    - DataID < 0x10 (short packet) → DONE.
    - Else latch WC, words = ceil(WC/4) → PAYLOAD.
  - PAYLOAD(3): each byte boundary, present the word on data_out with lsync_out=1; decrement word counter; last word → DONE.
  - DONE(4): lsync_out=0; wait for all data lanes LP-11 → IDLE.
- Any data lane returning to LP-11 in HUNT, HEADER or PAYLOAD → IDLE immediately; lsync_out drops the next cycle.
- ECC is not checked. WC = 0 → DONE with no payload words.
- Output timing:
  - clk_out free-runs, high 2 / low 2 cycles, phase-locked to the byte phase after sync.
  - data_out/lsync_out change on the clk_out falling edge, valid at the clk_out rising edge.
  - Latency: 2 clk_i cycles from the last bit of a byte to data_out.
- lsync_out stays high continuously across all payload words of one packet.
- Reset mid-packet: asynchronous return to IDLE, outputs 0.

Test Plan:
1. Reset asserted then released, lanes LP-11, no clock → all outputs 0, debug_state=0.
2. Clock lane LP-00 → fsyn_out=1 within 2 cycles; LP-11 → fsyn_out=0.
3. Data lanes LP-01 then LP-00, sync B8 on all lanes, header bytes 0x2B,0x60,0x09,0x00 (RAW10, WC=2400), 600 payload words cycling 0x00FF55AA, 0x0000FF55, 0xAA0000FF, 0x55AA0000, 0xFF55AA00 → exactly 600 words with lsync_out=1, in order, then lsync_out=0 and state DONE.
4. Ten back-to-back lines (LP-11 gap between them) within one fsyn_out window → ten lsync_out pulses of 600 words each.
5. Short packet (DataID=0x00) → no lsync_out, state DONE, returns IDLE on LP-11.
6. Data lanes forced LP-11 mid-payload → lsync_out drops, state IDLE; next line received correctly.
